// File: rtl/led_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module  : led_uart_reporter
// Brief   : Reports each new LED bus value as "HH\r\n" on an 8N1 UART line.
// Revision: 1.0 - initial release
// ============================================================================
module led_uart_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MSG_BYTES    = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iLed,
    output logic       oTxd,
    output logic       oBusy,
    output logic       oDropped
);

    localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [1:0]         c_LAST_BYTE = 2'(MSG_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [7:0]         r_led_q;
    logic [7:0]         r_shadow;
    logic [7:0]         r_msg;
    logic [7:0]         r_pend;
    logic               r_pend_valid;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [1:0]         r_byte_idx;
    logic               r_txd;
    logic               r_busy;
    logic               r_dropped;

    state_t             w_state_nxt;
    logic [7:0]         w_shadow_nxt;
    logic [7:0]         w_msg_nxt;
    logic [7:0]         w_pend_nxt;
    logic               w_pend_valid_nxt;
    logic [c_CNT_W-1:0] w_bit_cnt_nxt;
    logic [2:0]         w_bit_idx_nxt;
    logic [1:0]         w_byte_idx_nxt;
    logic [7:0]         w_byte_nxt;
    logic               w_txd_nxt;
    logic               w_busy_nxt;
    logic               w_dropped_nxt;
    logic               w_change;
    logic               w_bit_end;
    logic               w_msg_end;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        w_change         = (r_led_q != r_shadow);
        w_bit_end        = (r_bit_cnt == c_CNT_MAX);
        w_msg_end        = (r_state == ST_STOP) && w_bit_end && (r_byte_idx == c_LAST_BYTE);

        w_state_nxt      = r_state;
        w_shadow_nxt     = w_change ? r_led_q : r_shadow;
        w_msg_nxt        = r_msg;
        w_pend_nxt       = r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_bit_cnt_nxt    = r_bit_cnt + c_CNT_ONE;
        w_bit_idx_nxt    = r_bit_idx;
        w_byte_idx_nxt   = r_byte_idx;
        w_dropped_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_bit_cnt_nxt = '0;
                if (w_change) begin
                    w_state_nxt    = ST_START;
                    w_msg_nxt      = r_led_q;
                    w_byte_idx_nxt = 2'd0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt   = ST_DATA;
                    w_bit_cnt_nxt = '0;
                    w_bit_idx_nxt = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    if (r_byte_idx != c_LAST_BYTE) begin
                        w_state_nxt    = ST_START;
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                    end else if (w_change || r_pend_valid) begin
                        // A change landing on the final stop cycle is sent directly, back-to-back
                        w_state_nxt      = ST_START;
                        w_byte_idx_nxt   = 2'd0;
                        w_msg_nxt        = w_change ? r_led_q : r_pend;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if ((r_state != ST_IDLE) && w_change) begin
            w_dropped_nxt = r_pend_valid;
            if (!w_msg_end) begin
                w_pend_nxt       = r_led_q;
                w_pend_valid_nxt = 1'b1;
            end
        end

        case (w_byte_idx_nxt)
            2'd0:    w_byte_nxt = f_hex(w_msg_nxt[7:4]);
            2'd1:    w_byte_nxt = f_hex(w_msg_nxt[3:0]);
            2'd2:    w_byte_nxt = 8'h0D;
            default: w_byte_nxt = 8'h0A;
        endcase

        // Line level is registered from the next-state view so oTxd is glitch-free
        case (w_state_nxt)
            ST_START: w_txd_nxt = 1'b0;
            ST_DATA:  w_txd_nxt = w_byte_nxt[w_bit_idx_nxt];
            default:  w_txd_nxt = 1'b1;
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_led_q      <= 8'h00;
            r_shadow     <= 8'h00;
            r_msg        <= 8'h00;
            r_pend       <= 8'h00;
            r_pend_valid <= 1'b0;
            r_bit_cnt    <= '0;
            r_bit_idx    <= 3'd0;
            r_byte_idx   <= 2'd0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_led_q      <= iLed;
            r_shadow     <= w_shadow_nxt;
            r_msg        <= w_msg_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_txd        <= w_txd_nxt;
            r_busy       <= w_busy_nxt;
            r_dropped    <= w_dropped_nxt;
        end
    end

    assign oTxd     = r_txd;
    assign oBusy    = r_busy;
    assign oDropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_led_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_uart_reporter
// Brief   : Directed + randomized bench with a UART receiver model for led_uart_reporter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_uart_reporter;

    localparam int CPB = 4;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] iLed  = 8'h00;
    logic       oTxd;
    logic       oBusy;
    logic       oDropped;

    int         checks    = 0;
    int         errors    = 0;
    int         busy_cyc  = 0;
    int         busy_fall = 0;
    int         drop_cnt  = 0;
    int         rx_ferr   = 0;
    int         rd_ptr    = 0;
    logic [7:0] rx_q[$];
    string      c_hexd    = "0123456789ABCDEF";

    led_uart_reporter #(.CLKS_PER_BIT(CPB), .MSG_BYTES(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .iLed     (iLed),
        .oTxd     (oTxd),
        .oBusy    (oBusy),
        .oDropped (oDropped)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic rx_wait(input int n, inout logic ab);
        repeat (n) begin
            @(negedge Clock);
            if (Reset) ab = 1'b1;
        end
    endtask

    // Receiver model: 8N1, samples near mid-bit, drops any frame cut by reset
    initial begin : rx_mon
        logic [7:0] b;
        logic       ab;
        forever begin
            @(negedge Clock);
            if (!Reset && oTxd === 1'b0) begin
                ab = 1'b0;
                b  = 8'h00;
                rx_wait(CPB / 2, ab);
                for (int i = 0; i < 8 && !ab; i++) begin
                    rx_wait(CPB, ab);
                    b[i] = oTxd;
                end
                if (!ab) rx_wait(CPB, ab);
                if (!ab) begin
                    if (oTxd !== 1'b1) rx_ferr++;
                    rx_q.push_back(b);
                end
            end
        end
    end

    initial begin : busy_mon
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge Clock);
            if (oBusy === 1'b1) busy_cyc++;
            if (oDropped === 1'b1) drop_cnt++;
            if (prev && oBusy !== 1'b1) busy_fall++;
            prev = (oBusy === 1'b1);
        end
    end

    task automatic wait_idle(input string tag, input int maxc);
        int n;
        n = 0;
        while (oBusy !== 1'b0 && n < maxc) begin
            @(negedge Clock);
            n++;
        end
        chk({tag, ".idle"}, {31'b0, oBusy}, 32'd0);
        step(1);
    endtask

    task automatic check_msg(input string tag, input logic [7:0] val);
        logic [7:0] e[4];
        int         n;
        e[0] = c_hexd[val[7:4]];
        e[1] = c_hexd[val[3:0]];
        e[2] = 8'h0D;
        e[3] = 8'h0A;
        n = 0;
        while (rx_q.size() < rd_ptr + 4 && n < 2000) begin
            @(negedge Clock);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.b%0d", tag, i),
                (rd_ptr < rx_q.size()) ? {24'h0, rx_q[rd_ptr]} : 32'hDEAD, {24'h0, e[i]});
            rd_ptr++;
        end
    endtask

    initial begin : main
        int         b0, d0, f0, n0, fe0;
        logic [7:0] a, b, v1, v2, v;

        step(3);
        chk("rst.txd", {31'b0, oTxd}, 32'd1);
        chk("rst.busy", {31'b0, oBusy}, 32'd0);
        chk("rst.drop", {31'b0, oDropped}, 32'd0);
        Reset = 1'b0;
        step(8);
        chk("zero.busy", {31'b0, oBusy}, 32'd0);
        chk("zero.rx", rx_q.size(), 32'd0);

        // First report: latency and exact busy length
        b0 = busy_cyc; d0 = drop_cnt;
        iLed = 8'hA5;
        step(1);
        chk("t1.k.txd", {31'b0, oTxd}, 32'd1);
        chk("t1.k.busy", {31'b0, oBusy}, 32'd0);
        step(1);
        chk("t1.start.txd", {31'b0, oTxd}, 32'd0);
        chk("t1.start.busy", {31'b0, oBusy}, 32'd1);
        wait_idle("t1", 400);
        chk("t1.busycyc", busy_cyc - b0, 32'd160);
        chk("t1.drop", drop_cnt - d0, 32'd0);
        check_msg("t1", 8'hA5);

        // Constant input reports once only
        n0 = rx_q.size(); b0 = busy_cyc;
        iLed = 8'h3C;
        step(1000);
        chk("t2.nbytes", rx_q.size() - n0, 32'd4);
        chk("t2.busycyc", busy_cyc - b0, 32'd160);
        chk("t2.txd", {31'b0, oTxd}, 32'd1);
        check_msg("t2", 8'h3C);

        // Overwrite of pending value
        b0 = busy_cyc; d0 = drop_cnt; f0 = busy_fall;
        iLed = 8'h01; step(20);
        iLed = 8'h02; step(20);
        iLed = 8'h03; step(4);
        wait_idle("t3", 800);
        chk("t3.busycyc", busy_cyc - b0, 32'd320);
        chk("t3.drop", drop_cnt - d0, 32'd1);
        chk("t3.falls", busy_fall - f0, 32'd1);
        check_msg("t3.m0", 8'h01);
        check_msg("t3.m1", 8'h03);

        // A->B->A while busy: A is sent twice
        do a = 8'($urandom_range(255, 0)); while (a == 8'h03);
        do b = 8'($urandom_range(255, 0)); while (b == a);
        b0 = busy_cyc; d0 = drop_cnt;
        iLed = a; step(20);
        iLed = b; step(20);
        iLed = a; step(4);
        wait_idle("t4", 800);
        chk("t4.busycyc", busy_cyc - b0, 32'd320);
        chk("t4.drop", drop_cnt - d0, 32'd1);
        check_msg("t4.m0", a);
        check_msg("t4.m1", a);

        // Change detected on the final stop cycle starts back-to-back
        do v1 = 8'($urandom_range(255, 0)); while (v1 == a);
        do v2 = 8'($urandom_range(255, 0)); while (v2 == v1);
        b0 = busy_cyc; f0 = busy_fall;
        iLed = v1; step(2);
        step(158);
        iLed = v2;
        step(1);
        chk("t5.stop.txd", {31'b0, oTxd}, 32'd1);
        step(1);
        chk("t5.b2b.busy", {31'b0, oBusy}, 32'd1);
        chk("t5.b2b.txd", {31'b0, oTxd}, 32'd0);
        wait_idle("t5", 800);
        chk("t5.busycyc", busy_cyc - b0, 32'd320);
        chk("t5.falls", busy_fall - f0, 32'd1);
        check_msg("t5.m0", v1);
        check_msg("t5.m1", v2);

        // Reset during data bit 3 of byte 1 (low nibble 0-7 keeps that bit at 0)
        do v = {4'($urandom_range(15, 1)), 4'($urandom_range(7, 0))}; while (v == v2);
        iLed = v; step(2);
        step(57);
        chk("t6.pre.busy", {31'b0, oBusy}, 32'd1);
        chk("t6.pre.txd", {31'b0, oTxd}, 32'd0);
        Reset = 1'b1;
        step(1);
        chk("t6.rst.txd", {31'b0, oTxd}, 32'd1);
        chk("t6.rst.busy", {31'b0, oBusy}, 32'd0);
        step(2);
        Reset = 1'b0;
        chk("t6.partial", rx_q.size() - rd_ptr, 32'd1);
        chk("t6.partial.b0", (rd_ptr < rx_q.size()) ? {24'h0, rx_q[rd_ptr]} : 32'hDEAD,
            {24'h0, c_hexd[v[7:4]]});
        rd_ptr = rx_q.size();
        b0 = busy_cyc;
        step(4);
        wait_idle("t6", 400);
        chk("t6.busycyc", busy_cyc - b0, 32'd160);
        check_msg("t6.fresh", v);

        // FF then 00, with stop-bit framing checked by the receiver
        fe0 = rx_ferr;
        iLed = 8'hFF; step(200);
        iLed = 8'h00; step(200);
        chk("t7.busy", {31'b0, oBusy}, 32'd0);
        check_msg("t7.ff", 8'hFF);
        check_msg("t7.00", 8'h00);

        // Random isolated values
        for (int k = 0; k < 4; k++) begin
            do v = 8'($urandom_range(255, 0)); while (v == iLed);
            iLed = v;
            step(4);
            wait_idle("t8", 400);
            check_msg($sformatf("t8.r%0d", k), v);
        end

        chk("all.ferr", rx_ferr - fe0, 32'd0);
        chk("all.extra", rx_q.size() - rd_ptr, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
